// File: rtl/game_pkg.sv
// Shared game types: round outcome reported by game_controller and the campaign sequencer state.
package game_pkg;

    typedef enum logic [1:0] {
        WAITING   = 2'd0,
        COUNTDOWN = 2'd1,
        SUCCESS   = 2'd2,
        FAILURE   = 2'd3
    } game_state_t;

    typedef enum logic {
        PLAYING = 1'b0,
        WON     = 1'b1
    } seq_state_t;

endpackage

// File: rtl/state_edge_detect.sv
// Two-stage history of a state bus; hit is high for the one cycle where the bus has just become MATCH.
module state_edge_detect #(
    parameter int           W     = 2,
    parameter logic [W-1:0] MATCH = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] state_in,
    output logic         hit
);

    logic [W-1:0] h0_r;
    logic [W-1:0] h1_r;

    // History shift register; cleared to the idle encoding (all zeros)
    always_ff @(posedge clk) begin
        if (rst) begin
            h0_r <= '0;
            h1_r <= '0;
        end else begin
            h0_r <= state_in;
            h1_r <= h0_r;
        end
    end

    assign hit = (h0_r == MATCH) && (h1_r != MATCH);

endmodule

// File: rtl/level_sequencer.sv
// Campaign/difficulty manager: advances level on each new SUCCESS, handles FAILURE, declares the win.
// Optional macro LEVEL_LIVES_EN enables the per-campaign lives budget (retry the level on failure).
module level_sequencer
    import game_pkg::*;
#(
    parameter int TIME_W       = 11,
    parameter int CNT_W        = 6,
    parameter int LVL_W        = 3,
    parameter int NUM_LEVELS   = 8,
    parameter int INIT_TIME    = 1500,
    parameter int TIME_STEP    = 100,
    parameter int MIN_TIME     = 500,
    parameter int INIT_BUTTONS = 6,
    parameter int BUTTON_STEP  = 1,
    parameter int MAX_BUTTONS  = 16,
    parameter int NUM_LIVES    = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  game_state_t                        game_state,
    output logic [TIME_W-1:0]                  initial_time,
    output logic [CNT_W-1:0]                   button_count,
    output logic [LVL_W-1:0]                   level_num,
    output logic [$clog2(NUM_LIVES+1)-1:0]     lives_left,
    output logic                               level_up,
    output logic                               game_over,
    output logic                               campaign_won
);

    localparam int                 LIVES_W    = $clog2(NUM_LIVES + 1);
    localparam logic [TIME_W-1:0]  INIT_T     = TIME_W'(INIT_TIME);
    localparam logic [TIME_W-1:0]  STEP_T     = TIME_W'(TIME_STEP);
    localparam logic [TIME_W-1:0]  MIN_T      = TIME_W'(MIN_TIME);
    localparam logic [TIME_W-1:0]  FLOOR_T    = TIME_W'(MIN_TIME + TIME_STEP);
    localparam logic [CNT_W-1:0]   INIT_B     = CNT_W'(INIT_BUTTONS);
    localparam logic [CNT_W:0]     STEP_B     = (CNT_W+1)'(BUTTON_STEP);
    localparam logic [CNT_W:0]     MAX_B      = (CNT_W+1)'(MAX_BUTTONS);
    localparam logic [LVL_W-1:0]   LAST_LVL   = LVL_W'(NUM_LEVELS - 1);
    localparam logic [LIVES_W-1:0] FULL_LIVES = LIVES_W'(NUM_LIVES);

    seq_state_t          state_r;
    logic                succ_edge_s;
    logic                fail_edge_s;
    logic [TIME_W-1:0]   next_time_s;
    logic [CNT_W:0]      btn_sum_s;
    logic [CNT_W-1:0]    next_btn_s;

    state_edge_detect #(.W(2), .MATCH(SUCCESS)) u_succ_edge (
        .clk      (clk),
        .rst      (rst),
        .state_in (game_state),
        .hit      (succ_edge_s)
    );

    state_edge_detect #(.W(2), .MATCH(FAILURE)) u_fail_edge (
        .clk      (clk),
        .rst      (rst),
        .state_in (game_state),
        .hit      (fail_edge_s)
    );

    // Next-level difficulty: timer saturates at MIN_TIME, button count at MAX_BUTTONS (one extra bit for carry)
    always_comb begin
        next_time_s = MIN_T;
        if (initial_time >= FLOOR_T) begin
            next_time_s = initial_time - STEP_T;
        end else begin
            next_time_s = MIN_T;
        end
        btn_sum_s  = {1'b0, button_count} + STEP_B;
        next_btn_s = btn_sum_s[CNT_W-1:0];
        if (btn_sum_s > MAX_B) begin
            next_btn_s = MAX_B[CNT_W-1:0];
        end else begin
            next_btn_s = btn_sum_s[CNT_W-1:0];
        end
    end

`ifdef LEVEL_LIVES_EN
    localparam logic [LIVES_W-1:0] ONE_LIFE = LIVES_W'(1);
    logic [LIVES_W-1:0] lives_r;
    assign lives_left = lives_r;
`else
    assign lives_left = FULL_LIVES;
`endif

    // Campaign FSM with registered difficulty outputs and single-cycle event pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= PLAYING;
            level_num    <= '0;
            initial_time <= INIT_T;
            button_count <= INIT_B;
`ifdef LEVEL_LIVES_EN
            lives_r      <= FULL_LIVES;
`endif
            level_up     <= 1'b0;
            game_over    <= 1'b0;
            campaign_won <= 1'b0;
        end else begin
            level_up  <= 1'b0;
            game_over <= 1'b0;
            case (state_r)
                PLAYING: begin
                    if (succ_edge_s) begin
                        if (level_num < LAST_LVL) begin
                            level_num    <= level_num + LVL_W'(1);
                            initial_time <= next_time_s;
                            button_count <= next_btn_s;
                            level_up     <= 1'b1;
                        end else begin
                            state_r      <= WON;
                            campaign_won <= 1'b1;
                        end
                    end else if (fail_edge_s) begin
`ifdef LEVEL_LIVES_EN
                        if (lives_r > ONE_LIFE) begin
                            lives_r <= lives_r - ONE_LIFE;
                        end else begin
                            lives_r      <= FULL_LIVES;
                            level_num    <= '0;
                            initial_time <= INIT_T;
                            button_count <= INIT_B;
                            game_over    <= 1'b1;
                        end
`else
                        level_num    <= '0;
                        initial_time <= INIT_T;
                        button_count <= INIT_B;
                        game_over    <= 1'b1;
`endif
                    end else begin
                        state_r <= PLAYING;
                    end
                end
                WON: begin
                    // Round edges are ignored here; only start leaves the won state
                    if (start) begin
                        state_r      <= PLAYING;
                        level_num    <= '0;
                        initial_time <= INIT_T;
                        button_count <= INIT_B;
`ifdef LEVEL_LIVES_EN
                        lives_r      <= FULL_LIVES;
`endif
                        campaign_won <= 1'b0;
                    end else begin
                        campaign_won <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= PLAYING;
                    level_num    <= '0;
                    initial_time <= INIT_T;
                    button_count <= INIT_B;
                    campaign_won <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer: cycle table plus hand-written campaign sequences; honours LEVEL_LIVES_EN.
module tb_level_sequencer;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start_b;
    game_state_t gs;
    game_state_t gs_b;

    logic [10:0] time_a, time_b;
    logic [5:0]  btn_a, btn_b;
    logic [2:0]  lvl_a;
    logic [3:0]  lvl_b;
    logic [1:0]  lives_a, lives_b;
    logic        up_a, over_a, won_a, up_b, over_b, won_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    level_sequencer dut_a (
        .clk(clk), .rst(rst), .start(start), .game_state(gs),
        .initial_time(time_a), .button_count(btn_a), .level_num(lvl_a),
        .lives_left(lives_a), .level_up(up_a), .game_over(over_a), .campaign_won(won_a)
    );

    level_sequencer #(.LVL_W(4), .NUM_LEVELS(16), .MAX_BUTTONS(10)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .game_state(gs_b),
        .initial_time(time_b), .button_count(btn_b), .level_num(lvl_b),
        .lives_left(lives_b), .level_up(up_b), .game_over(over_b), .campaign_won(won_b)
    );

    typedef struct {
        logic        rst;
        logic        start;
        game_state_t gs;
        int          lvl;
        int          tm;
        int          btn;
        int          lives;
        int          up;
        int          over;
        int          won;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic r, input logic s, input game_state_t g, input int l,
                                input int t, input int b, input int lv, input int u, input int o, input int w);
        vec_t v;
        v.rst = r; v.start = s; v.gs = g; v.lvl = l; v.tm = t; v.btn = b;
        v.lives = lv; v.up = u; v.over = o; v.won = w;
        return v;
    endfunction

    function automatic int m_time(input int l);
        int t;
        t = 1500 - 100 * l;
        return (t < 500) ? 500 : t;
    endfunction

    function automatic int m_btn(input int l, input int maxb);
        return ((6 + l) > maxb) ? maxb : (6 + l);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic round_a(input int l);
        gs = SUCCESS; step();
        chk($sformatf("r%0d_hold_lvl", l), int'(lvl_a), l);
        chk($sformatf("r%0d_hold_up", l), int'(up_a), 0);
        gs = SUCCESS; step();
        chk($sformatf("r%0d_lvl", l), int'(lvl_a), l + 1);
        chk($sformatf("r%0d_time", l), int'(time_a), m_time(l + 1));
        chk($sformatf("r%0d_btn", l), int'(btn_a), m_btn(l + 1, 16));
        chk($sformatf("r%0d_up", l), int'(up_a), 1);
        gs = WAITING; step();
        chk($sformatf("r%0d_up_clr", l), int'(up_a), 0);
    endtask

    task automatic fail_a(input int n, input int exp_lvl, input int exp_lives, input int exp_over);
        gs = FAILURE; step();
        gs = FAILURE; step();
        chk($sformatf("f%0d_lvl", n), int'(lvl_a), exp_lvl);
        chk($sformatf("f%0d_lives", n), int'(lives_a), exp_lives);
        chk($sformatf("f%0d_over", n), int'(over_a), exp_over);
        chk($sformatf("f%0d_time", n), int'(time_a), m_time(exp_lvl));
        chk($sformatf("f%0d_btn", n), int'(btn_a), m_btn(exp_lvl, 16));
        gs = WAITING; step();
        chk($sformatf("f%0d_over_clr", n), int'(over_a), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_b = 1'b0; gs = WAITING; gs_b = WAITING;

        vecs[0]  = mk(1'b1, 1'b0, WAITING, 0, 1500, 6, 3, 0, 0, 0);
        vecs[1]  = mk(1'b0, 1'b0, SUCCESS, 0, 1500, 6, 3, 0, 0, 0);
        vecs[2]  = mk(1'b0, 1'b0, SUCCESS, 1, 1400, 7, 3, 1, 0, 0);
        vecs[3]  = mk(1'b0, 1'b0, SUCCESS, 1, 1400, 7, 3, 0, 0, 0);
        vecs[4]  = mk(1'b0, 1'b0, SUCCESS, 1, 1400, 7, 3, 0, 0, 0);
        vecs[5]  = mk(1'b0, 1'b0, WAITING, 1, 1400, 7, 3, 0, 0, 0);
        vecs[6]  = mk(1'b0, 1'b0, SUCCESS, 1, 1400, 7, 3, 0, 0, 0);
        vecs[7]  = mk(1'b0, 1'b0, SUCCESS, 2, 1300, 8, 3, 1, 0, 0);
        vecs[8]  = mk(1'b0, 1'b0, WAITING, 2, 1300, 8, 3, 0, 0, 0);
        vecs[9]  = mk(1'b0, 1'b0, SUCCESS, 2, 1300, 8, 3, 0, 0, 0);
        vecs[10] = mk(1'b1, 1'b0, SUCCESS, 0, 1500, 6, 3, 0, 0, 0);
        vecs[11] = mk(1'b0, 1'b0, SUCCESS, 0, 1500, 6, 3, 0, 0, 0);
        vecs[12] = mk(1'b0, 1'b0, SUCCESS, 1, 1400, 7, 3, 1, 0, 0);
        vecs[13] = mk(1'b0, 1'b0, WAITING, 1, 1400, 7, 3, 0, 0, 0);
        vecs[14] = mk(1'b0, 1'b0, FAILURE, 1, 1400, 7, 3, 0, 0, 0);
`ifdef LEVEL_LIVES_EN
        vecs[15] = mk(1'b0, 1'b0, FAILURE, 1, 1400, 7, 2, 0, 0, 0);
        vecs[16] = mk(1'b0, 1'b0, WAITING, 1, 1400, 7, 2, 0, 0, 0);
        vecs[17] = mk(1'b0, 1'b1, WAITING, 1, 1400, 7, 2, 0, 0, 0);
`else
        vecs[15] = mk(1'b0, 1'b0, FAILURE, 0, 1500, 6, 3, 0, 1, 0);
        vecs[16] = mk(1'b0, 1'b0, WAITING, 0, 1500, 6, 3, 0, 0, 0);
        vecs[17] = mk(1'b0, 1'b1, WAITING, 0, 1500, 6, 3, 0, 0, 0);
`endif

        // Saturation on the long campaign instance: timer floor 500, buttons clamp at 10
        step();
        rst = 1'b0;
        for (int l = 0; l < 12; l++) begin
            gs_b = SUCCESS; step();
            gs_b = SUCCESS; step();
            gs_b = WAITING; step();
            chk($sformatf("b%0d_lvl", l), int'(lvl_b), l + 1);
            chk($sformatf("b%0d_time", l), int'(time_b), m_time(l + 1));
            chk($sformatf("b%0d_btn", l), int'(btn_b), m_btn(l + 1, 10));
        end

        for (int i = 0; i < 18; i++) begin
            rst = vecs[i].rst; start = vecs[i].start; gs = vecs[i].gs;
            step();
            chk($sformatf("v%0d_level", i), int'(lvl_a), vecs[i].lvl);
            chk($sformatf("v%0d_time", i), int'(time_a), vecs[i].tm);
            chk($sformatf("v%0d_buttons", i), int'(btn_a), vecs[i].btn);
            chk($sformatf("v%0d_lives", i), int'(lives_a), vecs[i].lives);
            chk($sformatf("v%0d_level_up", i), int'(up_a), vecs[i].up);
            chk($sformatf("v%0d_game_over", i), int'(over_a), vecs[i].over);
            chk($sformatf("v%0d_won", i), int'(won_a), vecs[i].won);
        end
        start = 1'b0;

        // Failure handling from the middle of the campaign
        rst = 1'b1; gs = WAITING; step(); rst = 1'b0;
        for (int l = 0; l < 3; l++) round_a(l);
`ifdef LEVEL_LIVES_EN
        fail_a(1, 3, 2, 0);
        fail_a(2, 3, 1, 0);
        fail_a(3, 0, 3, 1);
`else
        round_a(3);
        fail_a(1, 0, 3, 1);
`endif

        // Full campaign: win at the last level, extra success ignored, start restarts
        rst = 1'b1; gs = WAITING; step(); rst = 1'b0;
        for (int l = 0; l < 7; l++) round_a(l);
        gs = SUCCESS; step();
        gs = SUCCESS; step();
        chk("win_won", int'(won_a), 1);
        chk("win_no_up", int'(up_a), 0);
        chk("win_lvl", int'(lvl_a), 7);
        chk("win_time", int'(time_a), 800);
        chk("win_btn", int'(btn_a), 13);
        gs = WAITING; step();
        chk("win_hold", int'(won_a), 1);
        gs = SUCCESS; step();
        gs = SUCCESS; step();
        chk("extra_won", int'(won_a), 1);
        chk("extra_lvl", int'(lvl_a), 7);
        chk("extra_no_up", int'(up_a), 0);
        gs = WAITING; start = 1'b1; step();
        start = 1'b0;
        chk("restart_lvl", int'(lvl_a), 0);
        chk("restart_time", int'(time_a), 1500);
        chk("restart_btn", int'(btn_a), 6);
        chk("restart_won", int'(won_a), 0);
        chk("restart_lives", int'(lives_a), 3);
        step();
        chk("restart_won_hold", int'(won_a), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
